// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: accepts a word operation, walks a 1-bit ALU slice
// across the operands LSB-first and presents the registered word result and flags.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ALU_control_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] SLT_FIX = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // Full-adder slice; returns {carry_out, sum}.
  function automatic logic [1:0] slice_add(input logic a, input logic b, input logic cin);
    slice_add = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic             set_q;

  logic             is_addsub;
  logic             is_slt;
  logic             is_arith;
  logic             is_and;
  logic             is_or;
  logic             a_inv;
  logic             b_inv;
  logic             a_bit;
  logic             b_bit;
  logic [1:0]       add_out;
  logic             res_bit;
  logic             ovf_bit;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] work_nxt;
  logic [WIDTH-1:0] slt_word;

  assign is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_slt    = (op_q == OP_SLT);
  assign is_arith  = is_addsub || is_slt;
  assign is_and    = (op_q == OP_AND) || (op_q == OP_NOR);
  assign is_or     = (op_q == OP_OR);
  assign a_inv     = (op_q == OP_NOR);
  assign b_inv     = (op_q == OP_SUB) || is_slt || (op_q == OP_NOR);

  assign a_bit   = a_sh[0] ^ a_inv;
  assign b_bit   = b_sh[0] ^ b_inv;
  assign add_out = slice_add(a_bit, b_bit, carry);
  // Carry into the MSB is the carry register itself while the MSB is processed.
  assign ovf_bit = carry ^ add_out[1];

  always_comb begin
    res_bit = 1'b0;
    if (is_arith)
      res_bit = is_slt ? 1'b0 : add_out[0];
    else if (is_and)
      res_bit = a_bit & b_bit;
    else if (is_or)
      res_bit = a_bit | b_bit;
  end

  assign last_bit = (cnt == CNT_LAST);
  assign accept   = (state == IDLE) && start_i;
  assign work_nxt = {res_bit, work[WIDTH-1:1]};
  assign slt_word = {work[WIDTH-1:1], set_q};

  assign ready_o = (state == IDLE);
  assign done_o  = (state == DONE);

  // Control and architectural outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      result_o   <= '0;
      zero_o     <= 1'b1;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_i)
            state <= RUN;
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (last_bit) begin
            if (is_slt) begin
              state <= SLT_FIX;
            end else begin
              state      <= DONE;
              result_o   <= work_nxt;
              zero_o     <= (work_nxt == '0);
              cout_o     <= is_addsub & add_out[1];
              overflow_o <= is_addsub & ovf_bit;
            end
          end
        end
        SLT_FIX: begin
          state      <= DONE;
          result_o   <= slt_word;
          zero_o     <= (slt_word == '0);
          cout_o     <= 1'b0;
          overflow_o <= 1'b0;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand shift registers and slice state
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_sh  <= src1_i;
      b_sh  <= src2_i;
      op_q  <= ALU_control_i;
      work  <= '0;
      carry <= (ALU_control_i == OP_SUB) || (ALU_control_i == OP_SLT);
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      work  <= work_nxt;
      carry <= add_out[1];
      if (last_bit)
        set_q <= add_out[0] ^ ovf_bit;
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq: reset, arithmetic/logic ops, SLT, handshake.
module tb_alu_serial_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic [3:0]   ctl = 4'b0000;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         cout;
  logic         ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .src1_i(src1), .src2_i(src2),
    .ALU_control_i(ctl), .ready_o(ready), .done_o(done), .result_o(result),
    .zero_o(zero), .cout_o(cout), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    if (!ready) check({tag, "_ready_timeout"}, 64'(ready), 64'd1);
  endtask

  // Issues one op and returns the number of cycles from the start cycle to done.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    start = 1'b1; ctl = op; src1 = a; src2 = b;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                        input logic ec, input logic ev, input int elat);
    int lat;
    wait_ready(tag);
    issue(op, a, b, lat);
    check({tag, "_lat"},  64'(lat),    64'(elat));
    check({tag, "_res"},  64'(result), 64'(er));
    check({tag, "_zero"}, 64'(zero),   64'(ez));
    check({tag, "_cout"}, 64'(cout),   64'(ec));
    check({tag, "_ovf"},  64'(ovf),    64'(ev));
    step();
    check({tag, "_done_pulse"}, 64'(done),  64'd0);
    check({tag, "_ready_back"}, 64'(ready), 64'd1);
  endtask

  initial begin
    int lat;
    int hits;
    int t_prev;
    int t_first;
    logic prev_done;

    step(); step();
    rst = 1'b0;
    check("rst_ready",  64'(ready),  64'd1);
    check("rst_done",   64'(done),   64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero",   64'(zero),   64'd1);
    check("rst_cout",   64'(cout),   64'd0);
    check("rst_ovf",    64'(ovf),    64'd0);

    run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 33);
    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 33);
    run_op("sub_eq",   4'b0110, 32'd5,         32'd5,         32'h0000_0000, 1, 1, 0, 33);
    run_op("sub_ovf",  4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 1, 33);
    run_op("slt_lt",   4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 0, 0, 0, 34);
    run_op("slt_gt",   4'b0111, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1, 0, 0, 34);
    run_op("slt_pos",  4'b0111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0, 34);
    run_op("and",      4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 33);
    run_op("or",       4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 0, 33);
    run_op("nor",      4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 0, 33);
    run_op("undef",    4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0, 33);
    run_op("and_nz",   4'b0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0, 0, 33);

    // Reset in the middle of an ADD: outputs return to reset values, no done follows.
    wait_ready("mid_rst");
    start = 1'b1; ctl = 4'b0010; src1 = 32'd1; src2 = 32'd1;
    step();
    start = 1'b0;
    check("mid_rst_busy", 64'(ready), 64'd0);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ready",  64'(ready),  64'd1);
    check("mid_rst_done",   64'(done),   64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_zero",   64'(zero),   64'd1);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) hits++;
    end
    check("mid_rst_no_done", 64'(hits), 64'd0);

    // Start pulsed during RUN with different operands is ignored.
    wait_ready("ign");
    start = 1'b1; ctl = 4'b0010; src1 = 32'd3; src2 = 32'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    start = 1'b1; ctl = 4'b0110; src1 = 32'd100; src2 = 32'd1;
    step();
    start = 1'b0; src1 = 32'hDEAD_BEEF; src2 = 32'h0BAD_F00D; ctl = 4'b0001;
    lat = 7;
    while (!done && lat < 100) begin
      step();
      lat++;
    end
    check("ign_lat",  64'(lat),    64'd33);
    check("ign_res",  64'(result), 64'd7);
    check("ign_cout", 64'(cout),   64'd0);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) hits++;
    end
    check("ign_not_queued", 64'(hits), 64'd0);

    // start held high: one op per WIDTH+2 cycles, done pulses never adjacent.
    wait_ready("held");
    start = 1'b1; ctl = 4'b0010; src1 = 32'd1; src2 = 32'd2;
    hits = 0; t_prev = -1; t_first = -1; prev_done = 1'b0;
    for (int t = 1; t <= 110; t++) begin
      step();
      if (done) begin
        if (prev_done) check("held_adjacent", 64'd1, 64'd0);
        if (t_prev >= 0) check("held_period", 64'(t - t_prev), 64'(W + 2));
        else t_first = t;
        t_prev = t;
        hits++;
        check("held_res", 64'(result), 64'd3);
      end
      prev_done = done;
    end
    start = 1'b0;
    check("held_first", 64'(t_first), 64'd33);
    check("held_count", 64'(hits),    64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial 32-bit ALU sequencer for the lab CPU datapath. It is the driving end of the 1-bit ALU slice interface. It accepts a word-wide operation through a start/ready handshake and steps one internal 1-bit slice (A/B invert, carry chain, set/less, overflow) across the operand LSB-first, one bit per clock. It then presents the registered word result, zero, carry-out and overflow with a one-cycle done pulse. It is used where area matters more than latency, such as the multi-cycle CPU variant and slice-level verification.

## Interface

- WIDTH, 32, operand/result width in bits (≥2).
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  request; sampled only when ready_o=1.
- src1_i  in  WIDTH  operand A; captured at the accept edge.
- src2_i  in  WIDTH  operand B; captured at the accept edge.
- ALU_control_i  in  4  operation code; captured at the accept edge:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed)
  - 1100 NOR
- ready_o  out  1  high only in IDLE.
- done_o  out  1  one-cycle completion pulse.
- result_o  out  WIDTH  result of the last completed operation.
- zero_o  out  1  result_o == 0.
- cout_o  out  1  carry out of the MSB (ADD/SUB only, else 0).
- overflow_o  out  1  signed overflow (ADD/SUB only, else 0).

## Operation

- States:
  - IDLE: ready_o=1.
  - RUN: one bit per cycle; bit counter 0..WIDTH-1.
  - SLT_FIX: SLT only.
  - DONE: done_o=1.
- Transitions:
  - IDLE→RUN when start_i=1.
  - RUN→RUN while counter<WIDTH-1.
  - RUN→SLT_FIX after bit WIDTH-1 if the op is SLT, otherwise RUN→DONE.
  - SLT_FIX→DONE.
  - DONE→IDLE unconditionally.
- Accept: captures src1_i, src2_i and ALU_control_i into shift registers. Clears the work register. Sets carry to 1 for SUB/SLT and 0 otherwise.
- Slice control derived from the captured code:
  - A_invert=1 for NOR.
  - B_invert=1 for SUB, SLT and NOR.
  - Slice operation: AND for AND and NOR (NOR = ~A&~B), OR for OR, ADD for ADD/SUB/SLT.
- Each RUN cycle processes bit i:
  - Computes sum/logic from a_i, b_i and the carry register.
  - Writes the result bit into the work register (SLT writes 0).
  - Updates carry. Records carry-in of bit WIDTH-1 for overflow.
- At the MSB:
  - overflow = cin_msb ^ cout_msb.
  - set = sum_msb ^ overflow.
- SLT_FIX writes set into work bit 0.
- Entry to DONE loads result_o from the work register and loads cout_o and overflow_o. cout_o/overflow_o are forced to 0 for non-ADD/SUB codes. zero_o is derived from the loaded result_o.
- Undefined ALU_control_i: the op runs WIDTH cycles as a logic op that yields 0. Result 0, zero_o=1, flags 0.
- Arithmetic is modulo 2^WIDTH. Carry is 1 bit and is not sign-extended.

## Timing

- Reset (any state, including mid-RUN): next state IDLE, counter 0. Outputs after reset:
  - ready_o=1
  - done_o=0
  - result_o=0
  - zero_o=1
  - cout_o=0
  - overflow_o=0
- Accept edge E0: the rising edge where ready_o=1 and start_i=1. ready_o drops in the cycle after E0.
- Latency:
  - Non-SLT: done_o is high during the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after the start cycle.
  - SLT: one cycle later than non-SLT.
- ready_o returns high the cycle after done_o. Back-to-back throughput is WIDTH+2 cycles (SLT WIDTH+3).
- start_i while ready_o=0 is ignored, not queued. Operand changes after E0 have no effect.
- result_o and flags change only on DONE entry or reset. They are held stable between completions.
- done_o is never high for two consecutive cycles.

## Test plan

- Reset: assert rst_i mid-RUN of an ADD -> next cycle ready_o=1, done_o=0, result_o=0, zero_o=1, and no done pulse follows.
- ADD: 0x7FFFFFFF + 0x00000001 -> result_o=0x80000000, overflow_o=1, cout_o=0, zero_o=0. done_o goes high exactly 33 cycles after the start cycle.
- SUB: 5 - 5 -> result_o=0, zero_o=1, cout_o=1, overflow_o=0. SUB 0x80000000 - 1 -> 0x7FFFFFFF, overflow_o=1.
- SLT:
  - 0x80000000 vs 0x00000001 -> result_o=1, done at 34 cycles.
  - 0x00000001 vs 0x80000000 -> result_o=0, zero_o=1.
  - 0x7FFFFFFF vs 0xFFFFFFFF -> 0.
- Logic ops:
  - AND 0xF0F0F0F0, 0xFF00FF00 -> 0xF000F000.
  - OR -> 0xFFF0FFF0.
  - NOR 0, 0 -> 0xFFFFFFFF, flags 0.
  - Code 1111 -> result_o=0, zero_o=1.
- Handshake: pulse start_i with new operands during RUN -> ignored, and the original result is delivered. Hold start_i high continuously -> one op per WIDTH+2 cycles, with done_o pulses non-adjacent.
